forward_scoreboard: RTL and testbench
=====================================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 3, register-address width.
REQ-002 SHALL have parameter NSRC, default 2, source operands per instruction.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL use one clock; reset asynchronous, active-low.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port issue_valid  input  1  instruction present in ID.
REQ-008 SHALL have port issue_we  input  1  ID instruction writes a register.
REQ-009 SHALL have port issue_rd  input  REG_AW  ID destination register.
REQ-010 SHALL have port issue_is_load  input  1  ID instruction is LD.
REQ-011 SHALL have port issue_src  input  NSRC*REG_AW  ID source registers; slot i at bits [i*REG_AW +: REG_AW].
REQ-012 SHALL have port issue_src_used  input  NSRC  slot i actually read; immediates leave it 0.
REQ-013 SHALL have port mem_stall  input  1  cache miss; whole pipeline frozen.
REQ-014 SHALL have port flush  input  1  kill ID instruction (branch/jump taken).
REQ-015 SHALL have port stall_id  output  1  load-use hazard; hold IF/ID, insert bubble.
REQ-016 SHALL have port fwd_sel  output  2*NSRC  per EX source: 00 regfile, 01 MEM/WB, 10 EX/MEM.
REQ-017 SHALL have port stall_cnt  output  CNT_W  saturating count of load-use bubbles.

Function
REQ-018 SHALL hold three internal stage records (EX, MEM, WB); each holds valid, we, rd, is_load; EX also holds src and src_used.
REQ-019 SHALL drive stall_id combinationally: issue_valid & EX.valid & EX.we & EX.is_load & (some i: issue_src_used[i] & issue_src[i]==EX.rd).
REQ-020 SHALL drive fwd_sel slot i combinationally from registered state only: 10 if EX.src_used[i] & MEM.valid & MEM.we & MEM.rd==EX.src[i]; else 01 if the same test passes against WB; else 00.
REQ-021 SHALL give the younger stage (MEM) priority over WB on a match.
REQ-022 SHALL treat register 0 as an ordinary register; no zero-register exclusion.
REQ-023 SHALL force fwd_sel to 00 whenever EX.valid=0.
REQ-024 SHALL, at a clock edge with mem_stall=1, hold all stage records and stall_cnt unchanged, ignoring flush and stall_id.
REQ-025 SHALL, otherwise, advance WB<=MEM and MEM<=EX each edge.
REQ-026 SHALL load EX from the issue_* inputs when issue_valid & ~stall_id & ~flush; otherwise load EX as a bubble (valid=0).
REQ-027 SHALL give flush priority over stall_id; a flushed cycle counts no stall.
REQ-028 SHALL increment stall_cnt on an edge where stall_id & ~flush & ~mem_stall, saturating at 2^CNT_W-1 with no wrap.
REQ-029 SHALL never select 10 for a load in MEM; a mismatch between REQ-019 and REQ-020 is a design error flagged by assertion.
REQ-030 SHALL have no latency beyond one edge for the stage shift; outputs valid in the same cycle as inputs.

Reset
REQ-031 SHALL, with rst_n low, asynchronously clear all valid bits, all rd/src fields, and stall_cnt to 0.
REQ-032 SHALL drive stall_id=0 and fwd_sel=0 while in reset and in the first cycle after release.
REQ-033 SHALL discard in-flight records on reset mid-operation; no forwarding from pre-reset instructions.

Verification
REQ-034 SHALL cover EX-EX forwarding: ADD r3 then ADD r4,r3,r2 back-to-back -> second in EX gives fwd_sel slot0=10, slot1=00.
REQ-035 SHALL cover MEM-EX forwarding and priority: ADD r1; ADD r1; ADD r5,r1,r1 -> slot0=slot1=10; with one NOP between -> slot0=slot1=01.
REQ-036 SHALL cover load-use: LD r2 then ADD r6,r2,r0 -> stall_id=1 one cycle, stall_cnt 0->1, EX bubble, then ADD in EX with slot0=01.
REQ-037 SHALL cover cache-miss freeze: mem_stall=1 for 5 cycles during REQ-034 -> fwd_sel held at 10, records and stall_cnt unchanged, resumes identically.
REQ-038 SHALL cover flush with hazard: flush=1 and stall_id=1 together -> EX bubble, stall_cnt unchanged; immediate-only source (src_used=0) matching rd -> fwd_sel=00.
REQ-039 SHALL cover saturation and reset: CNT_W=2, five load-use stalls -> stall_cnt=3; rst_n low mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/forward_scoreboard.sv
// rtl/forward_scoreboard.sv - load-use hazard detection and EX operand forwarding select
// Tracks EX/MEM/WB destination records; stalls ID on load-use and picks bypass sources.
module forward_scoreboard #(
  parameter int REG_AW = 3,
  parameter int NSRC   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic                     issue_we,
  input  logic [REG_AW-1:0]        issue_rd,
  input  logic                     issue_is_load,
  input  logic [NSRC*REG_AW-1:0]   issue_src,
  input  logic [NSRC-1:0]          issue_src_used,
  input  logic                     mem_stall,
  input  logic                     flush,
  output logic                     stall_id,
  output logic [2*NSRC-1:0]        fwd_sel,
  output logic [CNT_W-1:0]         stall_cnt
);

  logic                   exValid, exWe, exIsLoad;
  logic [REG_AW-1:0]      exRd;
  logic [NSRC*REG_AW-1:0] exSrc;
  logic [NSRC-1:0]        exSrcUsed;
  logic                   memValid, memWe, memIsLoad;
  logic [REG_AW-1:0]      memRd;
  logic                   wbValid, wbWe, wbIsLoad;
  logic [REG_AW-1:0]      wbRd;

  logic [NSRC-1:0]        idHit;
  logic [NSRC-1:0]        memHit;
  logic [NSRC-1:0]        wbHit;
  logic                   loadEx;

  always_comb begin
    idHit = '0;
    for (int i = 0; i < NSRC; i++) begin
      idHit[i] = issue_src_used[i] && (issue_src[i*REG_AW +: REG_AW] == exRd);
    end
  end

  assign stall_id = issue_valid & exValid & exWe & exIsLoad & (|idHit);

  // MEM is younger than WB, so it wins whenever both hold the same register.
  always_comb begin
    memHit  = '0;
    wbHit   = '0;
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      memHit[i] = exValid && exSrcUsed[i] && memValid && memWe
                  && (memRd == exSrc[i*REG_AW +: REG_AW]);
      wbHit[i]  = exValid && exSrcUsed[i] && wbValid && wbWe
                  && (wbRd == exSrc[i*REG_AW +: REG_AW]);
      if (memHit[i]) begin
        fwd_sel[2*i +: 2] = 2'b10;
      end else if (wbHit[i]) begin
        fwd_sel[2*i +: 2] = 2'b01;
      end
    end
  end

  assign loadEx = issue_valid & ~stall_id & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exValid   <= 1'b0;
      exWe      <= 1'b0;
      exIsLoad  <= 1'b0;
      exRd      <= '0;
      exSrc     <= '0;
      exSrcUsed <= '0;
      memValid  <= 1'b0;
      memWe     <= 1'b0;
      memIsLoad <= 1'b0;
      memRd     <= '0;
      wbValid   <= 1'b0;
      wbWe      <= 1'b0;
      wbIsLoad  <= 1'b0;
      wbRd      <= '0;
      stall_cnt <= '0;
    end else if (!mem_stall) begin
      wbValid   <= memValid;
      wbWe      <= memWe;
      wbIsLoad  <= memIsLoad;
      wbRd      <= memRd;
      memValid  <= exValid;
      memWe     <= exWe;
      memIsLoad <= exIsLoad;
      memRd     <= exRd;
      if (loadEx) begin
        exValid   <= 1'b1;
        exWe      <= issue_we;
        exIsLoad  <= issue_is_load;
        exRd      <= issue_rd;
        exSrc     <= issue_src;
        exSrcUsed <= issue_src_used;
      end else begin
        exValid   <= 1'b0;
        exWe      <= 1'b0;
        exIsLoad  <= 1'b0;
        exRd      <= '0;
        exSrc     <= '0;
        exSrcUsed <= '0;
      end
      if (stall_id && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  // A load still in MEM has no data yet; the ID stall must have kept its consumer out of EX.
  a_noLoadBypass : assert property (@(posedge clk) disable iff (!rst_n)
    !(memIsLoad && (|memHit)));

  a_loadWrites : assert property (@(posedge clk) disable iff (!rst_n)
    !(wbValid && wbIsLoad && !wbWe));

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb/tb_forward_scoreboard.sv - directed bench for forward_scoreboard
module tb_forward_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       issue_valid;
  logic       issue_we;
  logic [2:0] issue_rd;
  logic       issue_is_load;
  logic [5:0] issue_src;
  logic [1:0] issue_src_used;
  logic       mem_stall;
  logic       flush;
  logic       stall_id;
  logic [3:0] fwd_sel;
  logic [15:0] stall_cnt;
  logic       stallId2;
  logic [3:0] fwdSel2;
  logic [1:0] stallCnt2;

  int total = 0;
  int bad   = 0;

  forward_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_is_load(issue_is_load), .issue_src(issue_src), .issue_src_used(issue_src_used),
    .mem_stall(mem_stall), .flush(flush),
    .stall_id(stall_id), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
  );

  forward_scoreboard #(.REG_AW(3), .NSRC(2), .CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_is_load(issue_is_load), .issue_src(issue_src), .issue_src_used(issue_src_used),
    .mem_stall(mem_stall), .flush(flush),
    .stall_id(stallId2), .fwd_sel(fwdSel2), .stall_cnt(stallCnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIssue(input logic v, input logic we, input logic [2:0] rd, input logic ld,
                          input logic [2:0] s0, input logic [2:0] s1, input logic [1:0] used);
    issue_valid    = v;
    issue_we       = we;
    issue_rd       = rd;
    issue_is_load  = ld;
    issue_src      = {s1, s0};
    issue_src_used = used;
  endtask

  task automatic nop();
    setIssue(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 2'b00);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_stall = 1'b0; flush = 1'b0;
    nop();
    #7;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", stall_id); end
    total++; if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL rst_fwd got=%b exp=0000", fwd_sel); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    setIssue(1'b1, 1'b1, 3'd6, 1'b0, 3'd0, 3'd0, 2'b11);
    #1;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL rel_stall got=%0b exp=0", stall_id); end
    total++; if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL rel_fwd got=%b exp=0000", fwd_sel); end
    drain();
  endtask

  task automatic test_ex_ex();
    setIssue(1'b1, 1'b1, 3'd3, 1'b0, 3'd1, 3'd2, 2'b11);
    tick();
    setIssue(1'b1, 1'b1, 3'd4, 1'b0, 3'd3, 3'd2, 2'b11);
    #1;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL exex_stall got=%0b exp=0", stall_id); end
    tick();
    nop();
    #1;
    total++; if (fwd_sel !== 4'b0010) begin bad++; $display("FAIL exex_fwd got=%b exp=0010", fwd_sel); end
    drain();
  endtask

  task automatic test_mem_ex();
    setIssue(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 3'd0, 2'b00);
    tick();
    setIssue(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 3'd0, 2'b00);
    tick();
    setIssue(1'b1, 1'b1, 3'd5, 1'b0, 3'd1, 3'd1, 2'b11);
    tick();
    nop();
    #1;
    total++; if (fwd_sel !== 4'b1010) begin bad++; $display("FAIL prio_fwd got=%b exp=1010", fwd_sel); end
    drain();
    setIssue(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 3'd0, 2'b00);
    tick();
    nop();
    tick();
    setIssue(1'b1, 1'b1, 3'd5, 1'b0, 3'd1, 3'd1, 2'b11);
    tick();
    nop();
    #1;
    total++; if (fwd_sel !== 4'b0101) begin bad++; $display("FAIL memex_fwd got=%b exp=0101", fwd_sel); end
    drain();
  endtask

  task automatic test_load_use();
    setIssue(1'b1, 1'b1, 3'd2, 1'b1, 3'd0, 3'd0, 2'b00);
    tick();
    setIssue(1'b1, 1'b1, 3'd6, 1'b0, 3'd2, 3'd0, 2'b11);
    #1;
    total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b exp=1", stall_id); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL lu_cnt0 got=%0d exp=0", stall_cnt); end
    tick();
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt1 got=%0d exp=1", stall_cnt); end
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL lu_unstall got=%0b exp=0", stall_id); end
    total++; if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL lu_bubble got=%b exp=0000", fwd_sel); end
    tick();
    nop();
    #1;
    total++; if (fwd_sel !== 4'b0001) begin bad++; $display("FAIL lu_fwd got=%b exp=0001", fwd_sel); end
    drain();
  endtask

  task automatic test_freeze();
    setIssue(1'b1, 1'b1, 3'd3, 1'b0, 3'd1, 3'd2, 2'b11);
    tick();
    setIssue(1'b1, 1'b1, 3'd4, 1'b0, 3'd3, 3'd2, 2'b11);
    tick();
    setIssue(1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 3'd0, 2'b00);
    mem_stall = 1'b1;
    #1;
    total++; if (fwd_sel !== 4'b0010) begin bad++; $display("FAIL frz_pre got=%b exp=0010", fwd_sel); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (fwd_sel !== 4'b0010) begin bad++; $display("FAIL frz_fwd[%0d] got=%b exp=0010", i, fwd_sel); end
      total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL frz_cnt[%0d] got=%0d exp=1", i, stall_cnt); end
    end
    mem_stall = 1'b0;
    setIssue(1'b1, 1'b1, 3'd0, 1'b0, 3'd4, 3'd3, 2'b11);
    #1;
    total++; if (fwd_sel !== 4'b0010) begin bad++; $display("FAIL frz_rel got=%b exp=0010", fwd_sel); end
    tick();
    nop();
    #1;
    total++; if (fwd_sel !== 4'b0110) begin bad++; $display("FAIL frz_resume got=%b exp=0110", fwd_sel); end
    drain();
  endtask

  task automatic test_flush();
    setIssue(1'b1, 1'b1, 3'd2, 1'b1, 3'd0, 3'd0, 2'b00);
    tick();
    setIssue(1'b1, 1'b1, 3'd6, 1'b0, 3'd2, 3'd0, 2'b01);
    flush = 1'b1;
    #1;
    total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL fl_stall got=%0b exp=1", stall_id); end
    tick();
    flush = 1'b0;
    nop();
    #1;
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL fl_cnt got=%0d exp=1", stall_cnt); end
    total++; if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL fl_bubble got=%b exp=0000", fwd_sel); end
    drain();
    setIssue(1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 3'd0, 2'b00);
    tick();
    setIssue(1'b1, 1'b1, 3'd4, 1'b0, 3'd3, 3'd3, 2'b00);
    tick();
    nop();
    #1;
    total++; if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL imm_fwd got=%b exp=0000", fwd_sel); end
    drain();
    setIssue(1'b1, 1'b1, 3'd5, 1'b1, 3'd0, 3'd0, 2'b00);
    tick();
    setIssue(1'b1, 1'b1, 3'd4, 1'b0, 3'd5, 3'd5, 2'b00);
    #1;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL imm_stall got=%0b exp=0", stall_id); end
    drain();
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      setIssue(1'b1, 1'b1, 3'd2, 1'b1, 3'd0, 3'd0, 2'b00);
      tick();
      setIssue(1'b1, 1'b1, 3'd6, 1'b0, 3'd2, 3'd0, 2'b01);
      #1;
      total++; if (stallId2 !== 1'b1) begin bad++; $display("FAIL sat_stall[%0d] got=%0b exp=1", i, stallId2); end
      tick();
      nop();
      tick();
    end
    total++; if (stallCnt2 !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d exp=3", stallCnt2); end
    total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL wide_cnt got=%0d exp=5", stall_cnt); end
    setIssue(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 3'd0, 2'b00);
    tick();
    setIssue(1'b1, 1'b1, 3'd2, 1'b1, 3'd1, 3'd0, 2'b01);
    tick();
    setIssue(1'b1, 1'b1, 3'd6, 1'b0, 3'd2, 3'd0, 2'b01);
    #1;
    total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL mid_stall got=%0b exp=1", stall_id); end
    total++; if (fwd_sel !== 4'b0010) begin bad++; $display("FAIL mid_fwd got=%b exp=0010", fwd_sel); end
    rst_n = 1'b0;
    #1;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL arst_stall got=%0b exp=0", stall_id); end
    total++; if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL arst_fwd got=%b exp=0000", fwd_sel); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL arst_cnt got=%0d exp=0", stall_cnt); end
    total++; if (stallCnt2 !== 2'd0) begin bad++; $display("FAIL arst_cnt2 got=%0d exp=0", stallCnt2); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL post_stall got=%0b exp=0", stall_id); end
    tick();
    total++; if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL post_fwd got=%b exp=0000", fwd_sel); end
    drain();
  endtask

  initial begin
    test_reset();
    test_ex_ex();
    test_mem_ex();
    test_load_use();
    test_freeze();
    test_flush();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
